// File: rtl/instr_pkg.sv
// Shared constants for the RV32I instruction encoder: immediate-type codes,
// opcode values, packed-word field positions and an immediate range helper.
package instr_pkg;

  // Immediate-type codes carried on in_immsrc (101 and 110 are illegal)
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_R = 3'b111;

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Least-significant bit of each fixed field in the packed word
  localparam int unsigned POS_RD  = 32'd7;
  localparam int unsigned POS_F3  = 32'd12;
  localparam int unsigned POS_RS1 = 32'd15;
  localparam int unsigned POS_RS2 = 32'd20;
  localparam int unsigned POS_F7  = 32'd25;

  // True when v[31:lsb] are all equal, i.e. v is a sign extension from bit lsb
  function automatic logic upper_same(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] sh;
    sh = 32'($signed(v) >>> lsb);
    return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate legality check and RV32I field packing.
module imm_pack
  import instr_pkg::*;
(
  input  logic [2:0]  immsrc,
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        legal,
  output logic [31:0] instr
);

  // Select the encoding format for the immediate type and judge the immediate range
  always_comb begin
    legal = 1'b0;
    instr = 32'h0000_0000;
    case (immsrc)
      IMM_I: begin
        legal = upper_same(imm, 32'd11);
        instr = {imm[11:0], rs1, funct3, rd, op};
      end
      IMM_S: begin
        legal = upper_same(imm, 32'd11);
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      end
      IMM_B: begin
        legal = !imm[0] && upper_same(imm, 32'd12);
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      end
      IMM_J: begin
        legal = !imm[0] && upper_same(imm, 32'd20);
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      IMM_U: begin
        legal = (imm[11:0] == 12'h000);
        instr = {imm[31:12], rd, op};
      end
      IMM_R: begin
        legal = 1'b1;
        instr = {funct7, rs2, rs1, funct3, rd, op};
      end
      default: begin
        legal = 1'b0;
        instr = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder streaming packed words with sequential
// write addresses. Requests with an illegal immediate are dropped after S1
// and counted in a saturating error counter.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32'd10,
  parameter int unsigned BASE_ADDR = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_immsrc,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clr,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);

  logic              s1_valid_r;
  logic [2:0]        s1_immsrc_r;
  logic [6:0]        s1_op_r;
  logic [4:0]        s1_rd_r;
  logic [4:0]        s1_rs1_r;
  logic [4:0]        s1_rs2_r;
  logic [2:0]        s1_f3_r;
  logic [6:0]        s1_f7_r;
  logic [31:0]       s1_imm_r;
  logic              s2_valid_r;
  logic [31:0]       s2_instr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        err_r;

  logic              pk_legal_s;
  logic [31:0]       pk_instr_s;
  logic              s1_advance_s;
  logic              in_fire_s;
  logic              s2_load_s;
  logic              out_fire_s;
  logic              s1_drop_s;

  imm_pack u_imm_pack (
    .immsrc (s1_immsrc_r),
    .op     (s1_op_r),
    .rd     (s1_rd_r),
    .rs1    (s1_rs1_r),
    .rs2    (s1_rs2_r),
    .funct3 (s1_f3_r),
    .funct7 (s1_f7_r),
    .imm    (s1_imm_r),
    .legal  (pk_legal_s),
    .instr  (pk_instr_s)
  );

  // An illegal request never waits for S2, so it always leaves S1 next edge
  assign s1_drop_s    = s1_valid_r && !pk_legal_s;
  assign s1_advance_s = !s2_valid_r || out_ready || s1_drop_s;
  assign in_ready     = !s1_valid_r || s1_advance_s;
  assign in_fire_s    = in_valid && in_ready;
  assign s2_load_s    = s1_valid_r && pk_legal_s && s1_advance_s;
  assign out_fire_s   = s2_valid_r && out_ready;

  assign out_valid = s2_valid_r;
  assign out_instr = s2_instr_r;
  assign out_addr  = addr_r;
  assign err_count = err_r;

  // S1: capture an accepted request and hold it until it can move on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_immsrc_r <= 3'b000;
      s1_op_r     <= 7'd0;
      s1_rd_r     <= 5'd0;
      s1_rs1_r    <= 5'd0;
      s1_rs2_r    <= 5'd0;
      s1_f3_r     <= 3'd0;
      s1_f7_r     <= 7'd0;
      s1_imm_r    <= 32'h0000_0000;
    end else if (in_fire_s) begin
      s1_valid_r  <= 1'b1;
      s1_immsrc_r <= in_immsrc;
      s1_op_r     <= in_op;
      s1_rd_r     <= in_rd;
      s1_rs1_r    <= in_rs1;
      s1_rs2_r    <= in_rs2;
      s1_f3_r     <= in_funct3;
      s1_f7_r     <= in_funct7;
      s1_imm_r    <= in_imm;
    end else if (s1_advance_s) begin
      s1_valid_r  <= 1'b0;
    end else begin
      s1_valid_r  <= s1_valid_r;
    end
  end

  // S2: hold the packed word stable until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_instr_r <= 32'h0000_0000;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      s2_instr_r <= pk_instr_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Write address: clear wins over the per-word increment, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r <= ADDR_BASE;
    end else if (addr_clr) begin
      addr_r <= ADDR_BASE;
    end else if (out_fire_s) begin
      addr_r <= addr_r + ADDR_ONE;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Saturating count of requests dropped for an illegal immediate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 8'd0;
    end else if (s1_drop_s && (err_r != 8'd255)) begin
      err_r <= err_r + 8'd1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodes from the RV32I
// format tables, illegal immediates, backpressure, address wrap/clear, reset
// and error saturation, then randomized traffic against a reference model.
module tb_instr_encoder;
  import instr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_immsrc = 3'b000;
  logic [6:0]  in_op = 7'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_ready = 1'b1;
  logic        addr_clr = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;
  logic        in_ready2, out_valid2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_count2;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_immsrc(in_immsrc), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .addr_clr(addr_clr), .err_count(err_count)
  );

  // Narrow-address twin sees identical stimulus; only its address wraps sooner
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_immsrc(in_immsrc), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .addr_clr(addr_clr), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int unsigned exp_cnt = 0;
  int          err_model = 0;
  int          acc_count = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_instr = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoder: value ranges and bit-slicing arithmetic from the ISA tables
  function automatic logic [31:0] ref_encode(input logic [2:0] t, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm, output bit ok);
    int          s;
    logic [31:0] regs, w;
    s    = $signed(imm);
    regs = (32'(rs1) << POS_RS1) | (32'(f3) << POS_F3);
    w    = 32'(op);
    ok   = 1'b0;
    case (t)
      IMM_I: begin
        ok = (s >= -2048) && (s <= 2047);
        w |= (fld(imm, 11, 0) << 20) | regs | (32'(rd) << POS_RD);
      end
      IMM_S: begin
        ok = (s >= -2048) && (s <= 2047);
        w |= (fld(imm, 11, 5) << 25) | (32'(rs2) << POS_RS2) | regs | (fld(imm, 4, 0) << 7);
      end
      IMM_B: begin
        ok = (s % 2 == 0) && (s >= -4096) && (s <= 4095);
        w |= (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (32'(rs2) << POS_RS2) | regs
           | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
      end
      IMM_J: begin
        ok = (s % 2 == 0) && (s >= -(1 << 20)) && (s < (1 << 20));
        w |= (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
           | (fld(imm, 19, 12) << 12) | (32'(rd) << POS_RD);
      end
      IMM_U: begin
        ok = (imm % 4096 == 0);
        w |= (imm & 32'hFFFF_F000) | (32'(rd) << POS_RD);
      end
      IMM_R: begin
        ok = 1'b1;
        w |= (32'(f7) << POS_F7) | (32'(rs2) << POS_RS2) | regs | (32'(rd) << POS_RD);
      end
      default: ok = 1'b0;
    endcase
    return w;
  endfunction

  // Called right after an accepting edge, while the driven inputs are unchanged
  task automatic record();
    bit          ok;
    logic [31:0] w;
    w = ref_encode(in_immsrc, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ok);
    acc_count++;
    if (ok) exp_q.push_back(w);
    else if (err_model < 255) err_model++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    bit acc = 1'b0;
    in_immsrc = t; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) record();
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Expects the word accepted on the previous edge to appear two cycles after acceptance
  task automatic expect_word(input string tag, input logic [31:0] instr, input int addr);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check(tag, out_instr, instr);
    check({tag, "_addr"}, 32'(out_addr), 32'(addr));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_imm(input logic [2:0] t);
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    case (t)
      IMM_I, IMM_S: v = int'($urandom_range(0, 4095)) - 2048;
      IMM_B:        v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      IMM_J:        v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      IMM_U:        return $urandom & 32'hFFFF_F000;
      default:      return $urandom;
    endcase
    return 32'(v);
  endfunction

  // Output monitor: scoreboard order, both address widths, stall stability
  always @(negedge clk) begin
    bit          fire;
    logic [31:0] e;
    fire = 1'b0;
    if (!rst_n) begin
      exp_cnt    = 0;
      stall_prev = 1'b0;
    end else begin
      if (out_valid && stall_prev) check("hold_instr", out_instr, held_instr);
      if (out_valid && out_ready) begin
        fire = 1'b1;
        if (exp_q.size() == 0) begin
          check("stale_word", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("instr", out_instr, e);
          check("addr", 32'(out_addr), exp_cnt % 1024);
          check("addr_w2", 32'(out_addr2), exp_cnt % 4);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_instr = out_instr;
      if (addr_clr) exp_cnt = 0;
      else if (fire) exp_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Single encodes, one per format; unused fields carry junk on purpose
    drive_req(IMM_I, OP_OPIMM, 5'd1, 5'd0, 5'd9, 3'd0, 7'h55, 32'd5);
    expect_word("enc_i", 32'h0050_0093, 0);
    drive_req(IMM_S, OP_STORE, 5'd31, 5'd1, 5'd2, 3'b010, 7'h7F, 32'd8);
    expect_word("enc_s", 32'h0020_A423, 1);
    drive_req(IMM_B, OP_BRANCH, 5'd3, 5'd0, 5'd0, 3'd0, 7'h01, 32'hFFFF_FFFC);
    expect_word("enc_b", 32'hFE00_0EE3, 2);
    drive_req(IMM_J, OP_JAL, 5'd1, 5'd7, 5'd12, 3'd5, 7'h22, 32'd8);
    expect_word("enc_j", 32'h0080_00EF, 3);
    drive_req(IMM_U, OP_LUI, 5'd5, 5'd17, 5'd4, 3'd6, 7'h11, 32'h1234_5000);
    expect_word("enc_u", 32'h1234_52B7, 4);
    drive_req(IMM_R, OP_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
    expect_word("enc_r", 32'h0020_81B3, 5);

    // Illegal immediates are dropped and counted; address does not move
    drive_req(IMM_I, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    idle(3);
    check("err_i2048", 32'(err_count), 32'd1);
    drive_req(IMM_I, OP_OPIMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    expect_word("after_drop", 32'h8001_8113, 6);
    drive_req(IMM_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    idle(3);
    check("err_b3", 32'(err_count), 32'd2);
    drive_req(3'b101, OP_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(3);
    check("err_src101", 32'(err_count), 32'd3);

    // Backpressure: 8 words with the output stalled for 5 cycles
    acc_count = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive_req(IMM_R, OP_OP, 5'(i + 1), 5'(i), 5'(2 * i), 3'(i), 7'(i), 32'd0);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_accepts", 32'(acc_count), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // addr_clr coincident with a handshake restarts the address at 0
    out_ready = 1'b0;
    drive_req(IMM_I, OP_OPIMM, 5'd4, 5'd4, 5'd0, 3'd1, 7'd0, 32'd100);
    for (int k = 0; k < 10 && !out_valid; k++) idle(1);
    addr_clr = 1'b1;
    out_ready = 1'b1;
    idle(1);
    addr_clr = 1'b0;
    drive_req(IMM_U, OP_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
    expect_word("clr_next", 32'hABCD_E3B7, 0);

    // Randomized traffic with random backpressure and occasional clears
    for (int c = 0; c < 400; c++) begin
      in_immsrc = 3'($urandom_range(0, 7));
      in_op = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      in_imm = gen_imm(in_immsrc);
      in_valid = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      addr_clr = ($urandom_range(0, 31) == 0);
      begin
        bit acc;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        if (acc) record();
        #1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; addr_clr = 1'b0;
    idle(6);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_err", 32'(err_count), 32'(err_model));

    // Reset with two words in flight
    out_ready = 1'b0;
    drive_req(IMM_R, OP_OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    drive_req(IMM_R, OP_OP, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
    rst_n = 1'b0;
    exp_q.delete();
    err_model = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_addr", 32'(out_addr), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(5);
    check("no_stale", 32'(out_valid), 32'd0);

    // Error counter saturation
    for (int i = 0; i < 300; i++)
      drive_req(3'b110, OP_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(3);
    check("err_sat", 32'(err_count), 32'(err_model));
    check("err_sat_w2", 32'(err_count2), 32'(err_model));
    check("w2_ready", 32'(in_ready2), 32'(in_ready));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V RV32I instruction encoder; the inverse of the opcode/immediate-type decode used in the core. It accepts decoded fields plus a 32-bit immediate and an immediate-type code, range-checks the immediate, and packs the fields into a 32-bit instruction word. It then streams the word with a sequential write address toward instruction memory, e.g. for a self-test program loader. Requests with an illegal immediate are dropped and counted.

## Interface
Parameters:
- ADDR_W, 10, width of the emitted word address counter
- BASE_ADDR, 0, address value for the first emitted word after reset or clear

Ports:
- clk  in  1  sole clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_immsrc  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 111 R (no immediate); 101/110 illegal
- in_op  in  7  opcode, copied to bits [6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  immediate in its architectural byte-offset/value form
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer ready
- out_instr  out  32  packed instruction
- out_addr  out  ADDR_W  BASE_ADDR + emitted-word count, modulo 2^ADDR_W
- addr_clr  in  1  sets the emitted-word count to 0
- err_count  out  8  saturating count of dropped requests

## Operation
- Packing (bit 31 on the left):
  - R: funct7|rs2|rs1|funct3|rd|op
  - I: imm[11:0]|rs1|funct3|rd|op
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - U: imm[31:12]|rd|op
- Legality rules:
  - I/S: imm[31:11] all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0.
  - R: imm ignored, always legal.
  - immsrc 101/110: always illegal.
- Illegal request: still handshaken on input and travels through S1. It is not loaded into S2 and does not advance the address. err_count increments by 1 when it leaves S1, saturating at 255.
- Address count:
  - +1 on out_valid && out_ready, wrapping at 2^ADDR_W.
  - addr_clr forces the count to 0 and wins over a simultaneous increment.
  - out_addr of the word held in S2 follows the count live.
- Unused field inputs for a type are ignored.

## Timing
- Two register stages:
  - S1 captures the request and holds it.
  - S2 holds the packed word and the error-free result.
- Latency: accepted in cycle N, out_valid high in cycle N+2 if the output is unstalled.
- Throughput: one word per cycle with out_ready held high.
- Handshake:
  - in_ready = !s1_valid || s1_advance.
  - s1_advance = !s2_valid || out_ready, or S1 holds an illegal request.
- While out_valid && !out_ready, out_instr is held stable. out_addr changes only on addr_clr.
- Reset (rst_n low at a clock edge):
  - in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_count=0.
  - In-flight S1/S2 contents are discarded.
  - Reset mid-stream drops those words and does not count them as errors.

## Structure
- Package instr_pkg:
  - immsrc localparams IMM_I..IMM_U, IMM_R.
  - Opcode constants.
  - Packed-word field positions.
- Sub-module imm_pack: combinational legality check and packing, instantiated between S1 and S2.
- Top: handshake, stage registers, address and error counters.

## Test plan
- Single-word encodes, checking out_instr and latency 2, with out_addr 0,1,2,3,4,5 in order:
  - I, op 0010011, rd=1, rs1=0, f3=0, imm=5 -> 0x00500093
  - S, op 0100011, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423
  - B, op 1100011, imm=-4 -> 0xFE000EE3
  - J, op 1101111, rd=1, imm=8 -> 0x008000EF
  - U, op 0110111, rd=5, imm=0x12345000 -> 0x123452B7
  - R, op 0110011, rd=3, rs1=1, rs2=2, f7=0 -> 0x002081B3
- Illegal requests:
  - I imm=2048 -> no out_valid, err_count=1, next legal word keeps the address.
  - B imm=3 -> err_count=2.
  - immsrc=101 -> err_count=3.
- Backpressure: stream 8 words with out_ready low for 5 cycles -> in_ready drops after 2 accepts, out_instr stable, all 8 emitted in order with contiguous addresses.
- Address edges:
  - ADDR_W=2: 5 words -> addresses 0,1,2,3,0.
  - addr_clr coincident with a handshake -> next address 0.
- Reset with 2 words in flight -> out_valid=0 next cycle, out_addr=BASE_ADDR, err_count=0, no stale word emitted afterward.
- Saturation: 300 illegal requests -> err_count=255.
